// File: rtl/pipe_step_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline step controller.
//   - command codes carried on i_cmd
//   - FSM state encoding, which is also exported on o_state
//   - default widths for the step request and the executed-cycle counter
package pipe_ctrl_pkg;

  localparam int unsigned NB_STEP_DEF = 16;
  localparam int unsigned NB_CNT_DEF  = 32;
  localparam int unsigned NB_CMD_DEF  = 2;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/pipe_step_ctrl_if.sv
// pipe_step_ctrl_if: debug-unit / pipeline side signals of the step controller.
//   master modport: debug unit + pipeline (drives commands, abort, halt_wb)
//   slave  modport: pipe_step_ctrl (drives ready, clk_en, status, cycle count)
// Signal names keep the controller's point of view (i_ = into controller).
interface pipe_step_ctrl_if #(
  parameter int unsigned NB_STEP = 16,
  parameter int unsigned NB_CNT  = 32,
  parameter int unsigned NB_CMD  = 2
);

  logic               i_cmd_valid;
  logic [NB_CMD-1:0]  i_cmd;
  logic [NB_STEP-1:0] i_step_n;
  logic               i_abort;
  logic               i_halt_wb;
  logic               o_cmd_ready;
  logic               o_dunit_clk_en;
  logic               o_busy;
  logic               o_done;
  logic               o_halted;
  logic [1:0]         o_state;
  logic [NB_CNT-1:0]  o_cycle_cnt;

  modport master (
    output i_cmd_valid, i_cmd, i_step_n, i_abort, i_halt_wb,
    input  o_cmd_ready, o_dunit_clk_en, o_busy, o_done, o_halted, o_state, o_cycle_cnt
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_step_n, i_abort, i_halt_wb,
    output o_cmd_ready, o_dunit_clk_en, o_busy, o_done, o_halted, o_state, o_cycle_cnt
  );

endinterface

// File: rtl/pipe_step_ctrl_step_down_counter.sv
// step_down_counter: remaining-cycle counter for STEP commands.
//   clk, reset_n : clock, async active-low reset (counter clears to 0)
//   load         : load load_val (a request of 0 is treated as 1)
//   load_val     : requested step count
//   dec          : consume one cycle; saturates at 0, never wraps
//   last         : the current cycle is the final one of the request
module step_down_counter #(
  parameter int unsigned NB_STEP = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [NB_STEP-1:0] load_val,
  input  logic               dec,
  output logic               last
);

  logic [NB_STEP-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? NB_STEP'(1) : load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - NB_STEP'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == NB_STEP'(1));

endmodule

// File: rtl/pipe_step_ctrl.sv
// pipe_step_ctrl: sequences the MIPS pipeline through the shared clock enable.
//   i_clk      : system clock
//   i_reset_n  : asynchronous active-low reset
//   bus        : pipe_step_ctrl_if.slave
//                in : i_cmd_valid, i_cmd (NOP/RUN/STEP/CLEAR), i_step_n, i_abort, i_halt_wb
//                out: o_cmd_ready, o_dunit_clk_en, o_busy, o_done, o_halted, o_state,
//                     o_cycle_cnt
// Optional feature macro PIPE_CYCLE_CNT_EN: when defined, o_cycle_cnt counts enabled
// cycles (wrapping, cleared by CLEAR); otherwise it is tied to 0.
// NB_STEP/NB_CNT must match the widths of the connected interface.
module pipe_step_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NB_STEP = NB_STEP_DEF,
  parameter int unsigned NB_CNT  = NB_CNT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  pipe_step_ctrl_if.slave bus
);

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   done_q, done_d;
  logic   busy, cmd_ready, accept, clk_en;
  logic   step_load, step_dec, step_last;
  logic [1:0] cmd;

  assign cmd       = bus.i_cmd[1:0];
  assign busy      = (state_q == StRun) || (state_q == StStep);
  assign cmd_ready = (state_q == StIdle) || (state_q == StDone);
  assign accept    = bus.i_cmd_valid && cmd_ready;
  // Abort is the only input allowed to gate the enable; it blocks the cycle it is seen in.
  assign clk_en    = busy && !bus.i_abort;

  step_down_counter #(
    .NB_STEP (NB_STEP)
  ) u_step_cnt (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .load     (step_load),
    .load_val (bus.i_step_n),
    .dec      (step_dec),
    .last     (step_last)
  );

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    done_d    = 1'b0;
    step_load = 1'b0;
    step_dec  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          case (cmd)
            CMD_RUN, CMD_STEP: begin
              if (halted_q) begin
                // A halted program cannot advance: finish with no enabled cycles.
                state_d = StDone;
                done_d  = 1'b1;
              end else if (cmd == CMD_RUN) begin
                state_d = StRun;
              end else begin
                state_d   = StStep;
                step_load = 1'b1;
              end
            end
            CMD_CLEAR: begin
              state_d  = StIdle;
              halted_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (bus.i_abort) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (bus.i_halt_wb) begin
          state_d  = StDone;
          done_d   = 1'b1;
          halted_d = 1'b1;
        end
      end
      StStep: begin
        if (bus.i_abort) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          step_dec = 1'b1;
          if (bus.i_halt_wb) begin
            state_d  = StDone;
            done_d   = 1'b1;
            halted_d = 1'b1;
          end else if (step_last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

`ifdef PIPE_CYCLE_CNT_EN
  logic [NB_CNT-1:0] cyc_q;
  logic              cyc_clr;

  assign cyc_clr = accept && (cmd == CMD_CLEAR);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc_q <= '0;
    end else if (cyc_clr) begin
      cyc_q <= '0;
    end else if (clk_en) begin
      cyc_q <= cyc_q + NB_CNT'(1);
    end
  end

  assign bus.o_cycle_cnt = cyc_q;
`else
  assign bus.o_cycle_cnt = '0;
`endif

  assign bus.o_cmd_ready    = cmd_ready;
  assign bus.o_dunit_clk_en = clk_en;
  assign bus.o_busy         = busy;
  assign bus.o_done         = done_q;
  assign bus.o_halted       = halted_q;
  assign bus.o_state        = state_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// tb_pipe_step_ctrl: directed bench for pipe_step_ctrl with a cycle-level reference model.
// Honours PIPE_CYCLE_CNT_EN when predicting o_cycle_cnt.
module tb_pipe_step_ctrl;

  localparam int MIDLE = 0, MRUN = 1, MSTEP = 2, MDONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pipe_step_ctrl_if bus ();

  pipe_step_ctrl dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: mode, remaining step budget, sticky halt, done pulse, counters.
  int          m_mode = MIDLE;
  int          m_left = 0;
  bit          m_halted = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_cnt = '0;
  int          m_en_total = 0;

  int en_obs = 0;
  int done_obs = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = MIDLE; m_left = 0; m_halted = 1'b0; m_done = 1'b0; m_cnt = '0;
    end else begin
      bit running;
      running = (m_mode == MRUN) || (m_mode == MSTEP);
      m_done = 1'b0;
      if (running && !bus.i_abort) begin
        m_cnt++;
        m_en_total++;
      end
      if (!running) begin
        if (bus.i_cmd_valid) begin
          if (bus.i_cmd == 2'b01 || bus.i_cmd == 2'b10) begin
            if (m_halted) begin
              m_mode = MDONE; m_done = 1'b1;
            end else if (bus.i_cmd == 2'b01) begin
              m_mode = MRUN;
            end else begin
              m_mode = MSTEP;
              m_left = (bus.i_step_n == 0) ? 1 : int'(bus.i_step_n);
            end
          end else if (bus.i_cmd == 2'b11) begin
            m_mode = MIDLE; m_halted = 1'b0; m_cnt = '0;
          end
        end
      end else if (bus.i_abort) begin
        m_mode = MDONE; m_done = 1'b1;
      end else begin
        if (m_mode == MSTEP) m_left--;
        if (bus.i_halt_wb) begin
          m_halted = 1'b1; m_mode = MDONE; m_done = 1'b1;
        end else if (m_mode == MSTEP && m_left == 0) begin
          m_mode = MDONE; m_done = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison, 3 time units after the negedge where inputs change.
  initial begin
    forever begin
      logic [31:0] cnt_exp;
      bit run_exp;
      @(negedge clk);
      #3;
      if (chk_on) begin
        run_exp = (m_mode == MRUN) || (m_mode == MSTEP);
`ifdef PIPE_CYCLE_CNT_EN
        cnt_exp = m_cnt;
`else
        cnt_exp = '0;
`endif
        check("clk_en", bus.o_dunit_clk_en, run_exp && !bus.i_abort);
        check("busy", bus.o_busy, run_exp);
        check("cmd_ready", bus.o_cmd_ready, !run_exp);
        check("state", bus.o_state, m_mode[1:0]);
        check("done", bus.o_done, m_done);
        check("halted", bus.o_halted, m_halted);
        check("cycle_cnt", bus.o_cycle_cnt, cnt_exp);
        if (bus.o_dunit_clk_en) en_obs++;
        if (bus.o_done) done_obs++;
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [15:0] n);
    @(negedge clk);
    bus.i_cmd_valid = 1'b1; bus.i_cmd = c; bus.i_step_n = n;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0; bus.i_cmd = 2'b00; bus.i_step_n = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #4;
  endtask

  initial begin
    int e0, m0, d0;
    bus.i_cmd_valid = 1'b0; bus.i_cmd = 2'b00; bus.i_step_n = '0;
    bus.i_abort = 1'b0; bus.i_halt_wb = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    idle(2);
    check("reset_state", bus.o_state, 2'b00);
    check("reset_ready", bus.o_cmd_ready, 1'b1);

    // STEP 3
    e0 = en_obs; m0 = m_en_total; d0 = done_obs;
    send(2'b10, 16'd3);
    idle(6);
    check("step3_dut_en", en_obs - e0, 3);
    check("step3_model_en", m_en_total - m0, 3);
    check("step3_done", done_obs - d0, 1);
    check("step3_state", bus.o_state, 2'b11);

    // STEP 0 behaves as STEP 1
    e0 = en_obs; m0 = m_en_total;
    send(2'b10, 16'd0);
    idle(4);
    check("step0_dut_en", en_obs - e0, 1);
    check("step0_model_en", m_en_total - m0, 1);

    // RUN, HALT in WB on the 10th enabled cycle
    e0 = en_obs; m0 = m_en_total;
    send(2'b01, 16'd0);
    repeat (9) @(negedge clk);
    bus.i_halt_wb = 1'b1;
    @(negedge clk);
    bus.i_halt_wb = 1'b0;
    idle(3);
    check("halt_dut_en", en_obs - e0, 10);
    check("halt_model_en", m_en_total - m0, 10);
    check("halt_halted", bus.o_halted, 1'b1);
    check("halt_state", bus.o_state, 2'b11);

    // STEP while halted: no enabled cycles, done still pulses
    e0 = en_obs; d0 = done_obs;
    send(2'b10, 16'd5);
    idle(3);
    check("halted_step_en", en_obs - e0, 0);
    check("halted_step_done", done_obs - d0, 1);

    // CLEAR
    send(2'b11, 16'd0);
    idle(2);
    check("clear_halted", bus.o_halted, 1'b0);
    check("clear_state", bus.o_state, 2'b00);
    check("clear_cnt", bus.o_cycle_cnt, 0);

    // RUN, abort and halt together on the 4th cycle
    e0 = en_obs; m0 = m_en_total;
    send(2'b01, 16'd0);
    repeat (3) @(negedge clk);
    bus.i_abort = 1'b1; bus.i_halt_wb = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0; bus.i_halt_wb = 1'b0;
    idle(2);
    check("abort_dut_en", en_obs - e0, 3);
    check("abort_model_en", m_en_total - m0, 3);
    check("abort_halted", bus.o_halted, 1'b0);
    check("abort_state", bus.o_state, 2'b11);

    // RUN presented while busy in STEP 8 is dropped
    e0 = en_obs; m0 = m_en_total;
    send(2'b10, 16'd8);
    repeat (2) @(negedge clk);
    send(2'b01, 16'd0);
    idle(10);
    check("drop_dut_en", en_obs - e0, 8);
    check("drop_model_en", m_en_total - m0, 8);
    check("drop_state", bus.o_state, 2'b11);
`ifdef PIPE_CYCLE_CNT_EN
    check("cnt_total", bus.o_cycle_cnt, 11);
`else
    check("cnt_total", bus.o_cycle_cnt, 0);
`endif

    // Abort outside RUN/STEP is ignored
    @(negedge clk);
    bus.i_abort = 1'b1;
    idle(2);
    bus.i_abort = 1'b0;
    check("abort_idle_state", bus.o_state, 2'b11);

    // Reset in the middle of RUN
    send(2'b01, 16'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_clk_en", bus.o_dunit_clk_en, 1'b0);
    check("rst_state", bus.o_state, 2'b00);
    check("rst_halted", bus.o_halted, 1'b0);
    check("rst_cnt", bus.o_cycle_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_state", bus.o_state, 2'b00);
    check("post_rst_ready", bus.o_cmd_ready, 1'b1);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
